gamma_lut_stream: RTL and testbench

- Programmable, multi-channel gamma-correction lookup for the ISP video pipeline.
- Replaces fixed-curve combinational gamma tables with per-channel RAM tables that software can load at run time.
- Pipelined at 2 cycles, with frame-sync signals delayed to match.
- Sits after colour correction and before output formatting.

---
 rtl/gamma_lut_stream_if.sv | 34 +++
 rtl/gamma_lut_stream.sv | 184 ++++++++++++++++++
 tb/tb_gamma_lut_stream.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gamma_lut_stream_if.sv
// Table-load configuration bus for gamma_lut_stream.
// With GAMMA_LUT_DBUF_EN the bus also carries the commit strobe and pending flag.
interface gamma_lut_stream_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CH_SEL_W   = 2
);
  logic                  cfg_we;
  logic [CH_SEL_W-1:0]   cfg_ch;
  logic [DATA_WIDTH-1:0] cfg_addr;
  logic [DATA_WIDTH-1:0] cfg_wdata;
  logic                  cfg_ready;
`ifdef GAMMA_LUT_DBUF_EN
  logic                  cfg_commit;
  logic                  cfg_pending;

  modport master (
    output cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_ready, cfg_pending
  );
  modport slave (
    input  cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_ready, cfg_pending
  );
`else
  modport master (
    output cfg_we, cfg_ch, cfg_addr, cfg_wdata,
    input  cfg_ready
  );
  modport slave (
    input  cfg_we, cfg_ch, cfg_addr, cfg_wdata,
    output cfg_ready
  );
`endif
endinterface

// File: rtl/gamma_lut_stream.sv
// Programmable per-channel gamma lookup, 2-cycle latency on pixel and sync paths.
// Optional GAMMA_LUT_DBUF_EN: active/shadow table banks swapped on vsync rising edge.
module gamma_lut_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned CH_SEL_W   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           gamma_en,
  input  logic                           per_frame_vsync,
  input  logic                           per_frame_href,
  input  logic                           per_frame_clken,
  input  logic [CHANNELS*DATA_WIDTH-1:0] per_img_data,
  output logic                           post_frame_vsync,
  output logic                           post_frame_href,
  output logic                           post_frame_clken,
  output logic [CHANNELS*DATA_WIDTH-1:0] post_img_data,
  gamma_lut_stream_if.slave              cfg
);
  localparam int unsigned DEPTH = 1 << DATA_WIDTH;
  localparam int unsigned PIX_W = CHANNELS * DATA_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  ready_d;
  logic [CHANNELS-1:0]   wr_en;
  logic [DATA_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  vsync_d1, href_d1, clken_d1, en_d1;
  logic [PIX_W-1:0]      data_d1;
  logic [PIX_W-1:0]      rd_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      cfg.cfg_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      cfg.cfg_ready <= ready_d;
    end
  end

  // Next state and table write port: identity fill during INIT, cfg writes in RUN
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = 1'b0;
    wr_en      = '0;
    wr_addr    = cfg.cfg_addr;
    wr_data    = cfg.cfg_wdata;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + DATA_WIDTH'(1);
        wr_en      = '1;
        wr_addr    = init_cnt_q;
        wr_data    = init_cnt_q;
        if (init_cnt_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        // Out-of-range channel selects match no table and are dropped
        for (int c = 0; c < CHANNELS; c++) begin
          wr_en[c] = cfg.cfg_we && (cfg.cfg_ch == CH_SEL_W'(c));
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Stage 1: sync, pixel and effective enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1 <= 1'b0;
      href_d1  <= 1'b0;
      clken_d1 <= 1'b0;
      en_d1    <= 1'b0;
      data_d1  <= '0;
    end else begin
      vsync_d1 <= per_frame_vsync;
      href_d1  <= per_frame_href;
      clken_d1 <= per_frame_clken;
      en_d1    <= gamma_en && (state_q == ST_RUN);
      data_d1  <= per_img_data;
    end
  end

  // Stage 2: table data or bypassed pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_data    <= '0;
    end else begin
      post_frame_vsync <= vsync_d1;
      post_frame_href  <= href_d1;
      post_frame_clken <= clken_d1;
      post_img_data    <= en_d1 ? rd_data : data_d1;
    end
  end

`ifdef GAMMA_LUT_DBUF_EN
  logic bank_sel_q, bank_sel_d;
  logic pending_q, pending_d;
  logic commit;
  logic vsync_rise;

  assign commit     = cfg.cfg_commit && (state_q == ST_RUN);
  assign vsync_rise = per_frame_vsync && !vsync_d1;

  // A commit on the vsync rising edge itself swaps immediately
  always_comb begin
    bank_sel_d = bank_sel_q;
    pending_d  = pending_q;
    if (vsync_rise && (pending_q || commit)) begin
      bank_sel_d = !bank_sel_q;
      pending_d  = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
      pending_q  <= pending_d;
    end
  end

  assign cfg.cfg_pending = pending_q;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] pix;
    logic [DATA_WIDTH-1:0] rd_q;

    assign pix = per_img_data[c*DATA_WIDTH +: DATA_WIDTH];

`ifdef GAMMA_LUT_DBUF_EN
    logic [DATA_WIDTH-1:0] bank0 [DEPTH];
    logic [DATA_WIDTH-1:0] bank1 [DEPTH];

    // INIT fills both banks; cfg writes land in the bank not being read
    always_ff @(posedge clk) begin
      if (wr_en[c] && ((state_q == ST_INIT) || bank_sel_q)) bank0[wr_addr] <= wr_data;
      if (wr_en[c] && ((state_q == ST_INIT) || !bank_sel_q)) bank1[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= bank_sel_q ? bank1[pix] : bank0[pix];
    end
`else
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en[c]) mem[wr_addr] <= wr_data;
    end

    // Captures the pre-write entry on a same-address collision
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= mem[pix];
    end
`endif

    assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_gamma_lut_stream.sv
// Self-checking bench for gamma_lut_stream: table model plus directed vectors.
// Exercises the GAMMA_LUT_DBUF_EN path too when that macro is defined.
module tb_gamma_lut_stream;
  localparam int unsigned DW    = 8;
  localparam int unsigned CH    = 3;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          gamma_en;
  logic          per_frame_vsync, per_frame_href, per_frame_clken;
  logic [23:0]   per_img_data;
  logic          post_frame_vsync, post_frame_href, post_frame_clken;
  logic [23:0]   post_img_data;

  always #5 clk = ~clk;

  gamma_lut_stream_if #(.DATA_WIDTH(DW), .CH_SEL_W(2)) cfg_if ();

  gamma_lut_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .CH_SEL_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .gamma_en         (gamma_en),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_data     (per_img_data),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_data    (post_img_data),
    .cfg              (cfg_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] g22(input int x);
    real r;
    r = 255.0 * $pow(x / 255.0, 2.2);
    return 8'($rtoi(r + 0.5));
  endfunction

  // Model: tables, 2-deep output queue, cycles since reset release
  logic [7:0]  m_act [CH][DEPTH];
  logic [26:0] m_s1, m_s2;
  int          m_cycles;
`ifdef GAMMA_LUT_DBUF_EN
  logic [7:0]  m_shd [CH][DEPTH];
  logic [7:0]  m_tmp [CH][DEPTH];
  logic        m_pend, m_vs_prev, m_cmt;
`endif

  initial begin
    logic        run;
    logic [23:0] e;
    logic [7:0]  pix;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1     = '0;
        m_s2     = '0;
        m_cycles = 0;
        for (int c = 0; c < CH; c++)
          for (int a = 0; a < DEPTH; a++) begin
            m_act[c][a] = 8'(a);
`ifdef GAMMA_LUT_DBUF_EN
            m_shd[c][a] = 8'(a);
`endif
          end
`ifdef GAMMA_LUT_DBUF_EN
        m_pend    = 1'b0;
        m_vs_prev = 1'b0;
`endif
      end else begin
        run  = (m_cycles >= DEPTH);
        m_s2 = m_s1;
        for (int c = 0; c < CH; c++) begin
          pix = per_img_data[c*8 +: 8];
          e[c*8 +: 8] = (gamma_en && run) ? m_act[c][pix] : pix;
        end
        m_s1 = {per_frame_vsync, per_frame_href, per_frame_clken, e};
        if (run && cfg_if.cfg_we && (cfg_if.cfg_ch < 2'd3)) begin
`ifdef GAMMA_LUT_DBUF_EN
          m_shd[cfg_if.cfg_ch][cfg_if.cfg_addr] = cfg_if.cfg_wdata;
`else
          m_act[cfg_if.cfg_ch][cfg_if.cfg_addr] = cfg_if.cfg_wdata;
`endif
        end
`ifdef GAMMA_LUT_DBUF_EN
        m_cmt = run && cfg_if.cfg_commit;
        if (per_frame_vsync && !m_vs_prev && (m_pend || m_cmt)) begin
          m_tmp  = m_act;
          m_act  = m_shd;
          m_shd  = m_tmp;
          m_pend = 1'b0;
        end else if (m_cmt) begin
          m_pend = 1'b1;
        end
        m_vs_prev = per_frame_vsync;
`endif
        m_cycles++;
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("model_data", 32'(post_img_data), 32'(m_s2[23:0]));
      chk("model_sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'(m_s2[26:24]));
      chk("model_ready", 32'(cfg_if.cfg_ready), 32'(m_cycles >= DEPTH));
`ifdef GAMMA_LUT_DBUF_EN
      chk("model_pending", 32'(cfg_if.cfg_pending), 32'(m_pend));
`endif
    end
  end

  initial begin
    logic [2:0] sync_hist [8];
    rst_n            = 1'b0;
    gamma_en         = 1'b1;
    per_frame_vsync  = 1'b0;
    per_frame_href   = 1'b0;
    per_frame_clken  = 1'b0;
    per_img_data     = 24'h4080C0;
    cfg_if.cfg_we    = 1'b0;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_addr  = 8'h00;
    cfg_if.cfg_wdata = 8'h00;
`ifdef GAMMA_LUT_DBUF_EN
    cfg_if.cfg_commit = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", 32'(post_img_data), 32'h0);
    chk("reset_ready", 32'(cfg_if.cfg_ready), 32'h0);

    // INIT: bypass for 256 cycles, ready only afterwards
    tick();
    rst_n          = 1'b1;
    per_frame_href = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      per_frame_clken = i[0];
      if (i == 100) begin
        @(negedge clk);
        chk("init_bypass_data", 32'(post_img_data), 32'h4080C0);
        chk("init_ready_low", 32'(cfg_if.cfg_ready), 32'h0);
      end
      if (i == 254) begin
        @(negedge clk);
        chk("init_ready_last", 32'(cfg_if.cfg_ready), 32'h0);
      end
    end
    @(negedge clk);
    chk("ready_after_init", 32'(cfg_if.cfg_ready), 32'h1);
    tick();
    tick();
    @(negedge clk);
    chk("identity_after_init", 32'(post_img_data), 32'h4080C0);

    // Load gamma-2.2 into channel 1 while random pixels stream through
    for (int a = 0; a < 256; a++) begin
      tick();
      cfg_if.cfg_we    = 1'b1;
      cfg_if.cfg_ch    = 2'd1;
      cfg_if.cfg_addr  = 8'(a);
      cfg_if.cfg_wdata = g22(a);
      per_img_data     = 24'($urandom);
      per_frame_vsync  = (a == 0);
      per_frame_href   = 1'($urandom_range(0, 1));
      per_frame_clken  = 1'($urandom_range(0, 1));
    end
    tick();
    cfg_if.cfg_we   = 1'b0;
    per_img_data    = 24'h4080C0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("gamma_ch1_0x80", 32'(post_img_data), 32'h4038C0);

    // Burst of ch1=0x80 pixels with gamma_en low on pixel 3
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 8) begin
        per_img_data    = 24'h108020;
        gamma_en        = (i != 3);
        per_frame_vsync = (i == 0);
        per_frame_href  = i[0];
        per_frame_clken = !i[1];
        sync_hist[i]    = {per_frame_vsync, per_frame_href, per_frame_clken};
      end else begin
        gamma_en = 1'b1;
      end
      @(negedge clk);
      if (i >= 2) begin
        chk("burst_ch1", 32'(post_img_data[15:8]), (i == 5) ? 32'h80 : 32'h38);
        chk("burst_sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'(sync_hist[i-2]));
      end
    end

    // Same-address read/write collision returns the old entry
    tick();
    per_img_data     = 24'h000010;
    per_frame_vsync  = 1'b0;
    per_frame_href   = 1'b1;
    per_frame_clken  = 1'b1;
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_addr  = 8'h10;
    cfg_if.cfg_wdata = 8'hAA;
    tick();
    cfg_if.cfg_we = 1'b0;
    tick();
    @(negedge clk);
    chk("collision_old", 32'(post_img_data[7:0]), 32'h10);
    tick();
    @(negedge clk);
    chk("collision_new", 32'(post_img_data[7:0]), 32'hAA);

    // Write to nonexistent channel 3 is dropped
    tick();
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_ch    = 2'd3;
    cfg_if.cfg_addr  = 8'h20;
    cfg_if.cfg_wdata = 8'h55;
    tick();
    cfg_if.cfg_we = 1'b0;
    per_img_data  = 24'h202020;
    tick();
    tick();
    @(negedge clk);
    chk("bad_ch_c0", 32'(post_img_data[7:0]), 32'h20);
    chk("bad_ch_c2", 32'(post_img_data[23:16]), 32'h20);

    // Mid-RUN reset clears outputs at once and INIT rebuilds identity
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(post_img_data), 32'h0);
    chk("midrst_sync", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'h0);
    chk("midrst_ready", 32'(cfg_if.cfg_ready), 32'h0);
    per_img_data = 24'h408010;
    repeat (2) @(posedge clk);
    tick();
    rst_n = 1'b1;
    repeat (256) tick();
    tick();
    tick();
    @(negedge clk);
    chk("identity_after_rerun", 32'(post_img_data), 32'h408010);

`ifdef GAMMA_LUT_DBUF_EN
    // Inverted channel-0 table into shadow, commit mid-frame, swap on vsync rise
    per_img_data    = 24'h000010;
    per_frame_vsync = 1'b0;
    for (int a = 0; a < 256; a++) begin
      tick();
      cfg_if.cfg_we     = 1'b1;
      cfg_if.cfg_ch     = 2'd0;
      cfg_if.cfg_addr   = 8'(a);
      cfg_if.cfg_wdata  = ~8'(a);
      cfg_if.cfg_commit = (a == 100);
    end
    tick();
    cfg_if.cfg_we     = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("dbuf_pending_set", 32'(cfg_if.cfg_pending), 32'h1);
    chk("dbuf_before_swap", 32'(post_img_data[7:0]), 32'h10);
    tick();
    per_frame_vsync = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("dbuf_after_swap", 32'(post_img_data[7:0]), 32'hEF);
    chk("dbuf_pending_clr", 32'(cfg_if.cfg_pending), 32'h0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
